mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Two-requester controller in front of the single-ported, multi-cycle block data memory (DataMemory).
- Accepts block read/write requests from the instruction-cache side (port 0) and the data-cache side (port 1), and grants the memory round-robin.
- Drives exactly one memory transaction at a time, waits out the memory latency, and returns a one-cycle response to the owning port.

## Interface
Parameters:
- BLOCK_SIZE, 16, block width in bytes; data buses are BLOCK_SIZE*8 bits.
- ADDR_W, 32, address width; addresses are block indices, passed through unchanged.

Ports (clock and reset, then N = 0, 1, then the memory side):
- clk  in  1  clock
- reset  in  1  synchronous, active-high; reset reset, clock clk
- pN_req_valid  in  1  request pending; must stay high with fields stable until accepted
- pN_req_write  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  block address
- pN_din  in  BLOCK_SIZE*8  write data
- pN_req_ready  out  1  request accepted this cycle when high together with pN_req_valid
- pN_resp_valid  out  1  one-cycle pulse: transaction complete
- pN_resp_dout  out  BLOCK_SIZE*8  read data (0 for writes); held until the next response to port N
- mem_is_input_valid  out  1  request strobe to memory
- mem_addr  out  ADDR_W  memory address
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- mem_din  out  BLOCK_SIZE*8  memory write data
- mem_is_output_valid  in  1  memory read data valid
- mem_dout  in  BLOCK_SIZE*8  memory read data
- mem_ready  in  1  memory idle; high only when its delay counter is 0

## Operation
**FSM states:** IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.

**IDLE**
- Grant goes to the single valid port.
- If both ports are valid, grant goes to the port not equal to last_grant.
- pN_req_ready = (state==IDLE) && grant==N, combinational from state and valids only.
- On acceptance:
  - latch owner, write, addr and din;
  - set last_grant = owner;
  - go to ISSUE.

**ISSUE**
- Drive mem_is_input_valid=1, mem_read=!write, mem_write=write, mem_addr/mem_din from the latched request.
- If mem_ready=1, go to WAIT; otherwise hold in ISSUE with outputs stable.

**WAIT**
- All mem_* outputs are 0.
- When mem_ready=1, go to RESP.
  - For a read, register mem_dout into pN_resp_dout[owner]; mem_is_output_valid must be 1 that cycle, and an assertion fires if it is not.
  - For a write, register 0.

**RESP**
- pN_resp_valid[owner]=1 for exactly this cycle; return to IDLE.
- There is no acceptance in RESP, so the memory has one idle cycle before the next issue.

**Rules**
- At most one outstanding transaction.
- The arbiter never asserts mem_read and mem_write together.
- Outputs for the non-owner port are never pulsed.
- Only one port is ever ready in a given cycle.

**Reset values:** state=IDLE, last_grant=1 (port 0 wins the first contention), every output 0, both resp_dout 0.

**Reset mid-transaction:** abandon the transaction, emit no response, go to IDLE. The memory shares the reset, so no stale completion can arrive.

## Timing
Cycle 0 is the acceptance cycle (valid && ready).
- Cycle 1: ISSUE; the memory latches the request at the end of cycle 1.
- Cycles 2 .. 2+DELAY: WAIT (DELAY+1 cycles).
- Cycle 3+DELAY: RESP, resp_valid high. With the memory DELAY=50 this is cycle 53.
- Cycle 4+DELAY: IDLE; the next acceptance is possible, giving a back-to-back throughput of one transaction per DELAY+4 cycles.
- DELAY=0 degenerates correctly: WAIT lasts 1 cycle and the response arrives in cycle 3.
- A write is committed in memory at the end of the last WAIT cycle, before its resp_valid.
- Requester inputs are sampled only in cycle 0. Changes afterwards have no effect.
- Dropping valid before ready is a protocol violation and is flagged by an assertion.

## Structure
**Shared package mem_arb_pkg:**
- state enum {IDLE, ISSUE, WAIT, RESP};
- port index constants PORT_I=0, PORT_D=1;
- the BLOCK_SIZE default.

**Sub-module rr_arbiter_2:**
- Combinational two-way round-robin pick from (valid0, valid1, last_grant) giving (grant, any).
- Owned by mem_arbiter; the FSM and datapath registers stay in mem_arbiter.

## Test plan
All scenarios use the memory with DELAY=50 and BLOCK_SIZE=16.
- **Single read:** p0 reads addr 0x10 after the memory was preloaded with 0xA5A5…A5 → p0_req_ready in cycle 0, mem_is_input_valid in cycle 1 only, p0_resp_valid in cycle 53 with dout=0xA5A5…A5, p1 silent.
- **Write then read:** p1 writes 0x0123…CDEF to addr 7, then reads addr 7 → write response with dout=0 in cycle 53; read accepted in cycle 54; read response in cycle 107 with 0x0123…CDEF.
- **Contention:** p0 and p1 both valid from reset and held → grants alternate 0,1,0,1; accepts at cycles 0, 54, 108, 162; never both ready in one cycle.
- **Back-to-back single port:** p0 keeps 4 reads pending to addresses 1–4 → accepts spaced exactly 54 cycles apart, responses in order with the matching data, exactly one resp_valid pulse each.
- **Reset mid-operation:** reset asserted in cycle 20 of a p1 read → all outputs 0 the next cycle, no p1_resp_valid, and a fresh p0 request afterwards completes in 53 cycles.
- **Assertion check:** mem_read and mem_write are never high together, and mem_is_input_valid is never high outside ISSUE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port block-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int unsigned BLOCK_SIZE_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on contention the port that did not win last time gets the grant.
module rr_arbiter_2
   import mem_arb_pkg::*;
(
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic any_o
);

   always_comb begin
      any_o = valid0_i | valid1_i;
      if (valid0_i && valid1_i) begin
         grant_o = ~last_grant_i;
      end else if (valid1_i) begin
         grant_o = PORT_D;
      end else begin
         grant_o = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-side and D-side block requests onto the single-ported multi-cycle memory,
// one transaction at a time, returning a one-cycle response to the owning port.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEFAULT,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    p0_req_valid,
   input  logic                    p0_req_write,
   input  logic [ADDR_W-1:0]       p0_addr,
   input  logic [BLOCK_SIZE*8-1:0] p0_din,
   output logic                    p0_req_ready,
   output logic                    p0_resp_valid,
   output logic [BLOCK_SIZE*8-1:0] p0_resp_dout,
   input  logic                    p1_req_valid,
   input  logic                    p1_req_write,
   input  logic [ADDR_W-1:0]       p1_addr,
   input  logic [BLOCK_SIZE*8-1:0] p1_din,
   output logic                    p1_req_ready,
   output logic                    p1_resp_valid,
   output logic [BLOCK_SIZE*8-1:0] p1_resp_dout,
   output logic                    mem_is_input_valid,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [BLOCK_SIZE*8-1:0] mem_din,
   input  logic                    mem_is_output_valid,
   input  logic [BLOCK_SIZE*8-1:0] mem_dout,
   input  logic                    mem_ready
);

   localparam int unsigned DataW = BLOCK_SIZE * 8;

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DataW-1:0]  din_q, din_d;
   logic              last_grant_q, last_grant_d;
   logic [DataW-1:0]  p0_dout_q, p0_dout_d;
   logic [DataW-1:0]  p1_dout_q, p1_dout_d;
   logic [DataW-1:0]  rd_data;
   logic              grant;
   logic              any;

   rr_arbiter_2 u_rr (
      .valid0_i     (p0_req_valid),
      .valid1_i     (p1_req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_o        (any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= PORT_I;
         write_q      <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         last_grant_q <= PORT_D;
         p0_dout_q    <= '0;
         p1_dout_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         last_grant_q <= last_grant_d;
         p0_dout_q    <= p0_dout_d;
         p1_dout_q    <= p1_dout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      addr_d       = addr_q;
      din_d        = din_q;
      last_grant_d = last_grant_q;
      p0_dout_d    = p0_dout_q;
      p1_dout_d    = p1_dout_q;
      rd_data      = write_q ? '0 : mem_dout;
      unique case (state_q)
         StIdle: begin
            if (any) begin
               owner_d      = grant;
               write_d      = grant ? p1_req_write : p0_req_write;
               addr_d       = grant ? p1_addr : p0_addr;
               din_d        = grant ? p1_din : p0_din;
               last_grant_d = grant;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            if (mem_ready) state_d = StWait;
         end
         StWait: begin
            if (mem_ready) begin
               if (owner_q == PORT_D) p1_dout_d = rd_data;
               else                   p0_dout_d = rd_data;
               state_d = StResp;
            end
         end
         StResp: begin
            // No acceptance here: gives the memory one idle cycle between transactions.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      p0_req_ready       = (state_q == StIdle) && any && (grant == PORT_I);
      p1_req_ready       = (state_q == StIdle) && any && (grant == PORT_D);
      p0_resp_valid      = (state_q == StResp) && (owner_q == PORT_I);
      p1_resp_valid      = (state_q == StResp) && (owner_q == PORT_D);
      p0_resp_dout       = p0_dout_q;
      p1_resp_dout       = p1_dout_q;
      mem_is_input_valid = 1'b0;
      mem_read           = 1'b0;
      mem_write          = 1'b0;
      mem_addr           = '0;
      mem_din            = '0;
      if (state_q == StIssue) begin
         mem_is_input_valid = 1'b1;
         mem_read           = ~write_q;
         mem_write          = write_q;
         mem_addr           = addr_q;
         mem_din            = din_q;
      end
   end

   a_read_data_valid : assert property (@(posedge clk) disable iff (reset)
      (state_q == StWait && mem_ready && !write_q) |-> mem_is_output_valid);

   a_p0_valid_held : assert property (@(posedge clk) disable iff (reset)
      (p0_req_valid && !p0_req_ready) |=> p0_req_valid);

   a_p1_valid_held : assert property (@(posedge clk) disable iff (reset)
      (p1_req_valid && !p1_req_ready) |=> p1_req_valid);

   a_no_read_write : assert property (@(posedge clk) disable iff (reset)
      !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter against a behavioural DELAY=50 block memory.
module tb_mem_arbiter;

   localparam int unsigned Delay = 50;
   localparam int unsigned DW    = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          p0_req_valid, p0_req_write, p0_req_ready, p0_resp_valid;
   logic [31:0]   p0_addr;
   logic [DW-1:0] p0_din, p0_resp_dout;
   logic          p1_req_valid, p1_req_write, p1_req_ready, p1_resp_valid;
   logic [31:0]   p1_addr;
   logic [DW-1:0] p1_din, p1_resp_dout;
   logic          mem_is_input_valid, mem_read, mem_write, mem_is_output_valid, mem_ready;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rw_both  = 0;
   int both_rdy = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.BLOCK_SIZE(16), .ADDR_W(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .p0_req_valid        (p0_req_valid),
      .p0_req_write        (p0_req_write),
      .p0_addr             (p0_addr),
      .p0_din              (p0_din),
      .p0_req_ready        (p0_req_ready),
      .p0_resp_valid       (p0_resp_valid),
      .p0_resp_dout        (p0_resp_dout),
      .p1_req_valid        (p1_req_valid),
      .p1_req_write        (p1_req_write),
      .p1_addr             (p1_addr),
      .p1_din              (p1_din),
      .p1_req_ready        (p1_req_ready),
      .p1_resp_valid       (p1_resp_valid),
      .p1_resp_dout        (p1_resp_dout),
      .mem_is_input_valid  (mem_is_input_valid),
      .mem_addr            (mem_addr),
      .mem_read            (mem_read),
      .mem_write           (mem_write),
      .mem_din             (mem_din),
      .mem_is_output_valid (mem_is_output_valid),
      .mem_dout            (mem_dout),
      .mem_ready           (mem_ready)
   );

   // Behavioural memory: latches a request while idle, counts down Delay, then completes.
   logic [DW-1:0] mem [256];
   int unsigned   dcnt;
   logic          pend, pend_wr, pre_we;
   logic [31:0]   pend_addr;
   logic [7:0]    pre_addr;
   logic [DW-1:0] pend_din, pre_data;

   assign mem_ready           = (dcnt == 0);
   assign mem_is_output_valid = pend && (dcnt == 0) && !pend_wr;
   assign mem_dout            = mem_is_output_valid ? mem[pend_addr[7:0]] : '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (reset) begin
         dcnt <= 0;
         pend <= 1'b0;
      end else if (pend && dcnt == 0) begin
         if (pend_wr) mem[pend_addr[7:0]] <= pend_din;
         pend <= 1'b0;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
      end else if (mem_is_input_valid) begin
         pend      <= 1'b1;
         pend_wr   <= mem_write;
         pend_addr <= mem_addr;
         pend_din  <= mem_din;
         dcnt      <= Delay;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (mem_read && mem_write) rw_both = rw_both + 1;
      if (p0_req_ready && p1_req_ready) both_rdy = both_rdy + 1;
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int port, input logic v, input logic wr, input logic [31:0] a,
                        input logic [DW-1:0] d);
      if (port == 0) begin
         p0_req_valid = v; p0_req_write = wr; p0_addr = a; p0_din = d;
      end else begin
         p1_req_valid = v; p1_req_write = wr; p1_addr = a; p1_din = d;
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issues one request on an idle arbiter and follows it one cycle past its response.
   task automatic run_txn(input int port, input logic wr, input logic [31:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_dout,
                          input string tag, output int acc_cyc);
      int start, rel, iv_cnt, iv_first, resp_rel, own, other;
      logic [DW-1:0] dout;
      bit accepted, done;
      accepted = 0; done = 0; iv_cnt = 0; iv_first = -1; resp_rel = -1;
      own = 0; other = 0; dout = '0; acc_cyc = -1;
      drive(port, 1'b1, wr, a, d);
      #1;
      start = cyc;
      for (int k = 0; k < 200 && !done; k++) begin
         if (!accepted && ((port == 0) ? p0_req_ready : p1_req_ready)) begin
            accepted = 1;
            acc_cyc  = cyc;
         end
         if (accepted) begin
            rel = cyc - acc_cyc;
            if (mem_is_input_valid) begin
               iv_cnt++;
               if (iv_first < 0) iv_first = rel;
            end
            if ((port == 0) ? p1_resp_valid : p0_resp_valid) other++;
            if ((port == 0) ? p0_resp_valid : p1_resp_valid) begin
               own++;
               resp_rel = rel;
               dout     = (port == 0) ? p0_resp_dout : p1_resp_dout;
            end
            if (rel == 54) done = 1;
         end
         if (!done) begin
            @(negedge clk);
            if (accepted && cyc == acc_cyc + 1) drive(port, 1'b0, wr, a, d);
            #1;
         end
      end
      drive(port, 1'b0, wr, a, d);
      check_eq({tag, " accepted"}, DW'(accepted), DW'(1));
      check_eq({tag, " accept_cycle"}, DW'(acc_cyc), DW'(start));
      check_eq({tag, " issue_count"}, DW'(iv_cnt), DW'(1));
      check_eq({tag, " issue_cycle"}, DW'(iv_first), DW'(1));
      check_eq({tag, " resp_cycle"}, DW'(resp_rel), DW'(53));
      check_eq({tag, " resp_pulses"}, DW'(own), DW'(1));
      check_eq({tag, " other_port_pulses"}, DW'(other), DW'(0));
      check_eq({tag, " dout"}, dout, exp_dout);
   endtask

   initial begin
      logic [DW-1:0] a5, pat;
      int acc_a, acc_b, prev, rst_cyc, n_acc, p0_n, p1_n, cont_both, pulses, ivs;
      int acc_c[8];
      int acc_p[8];
      a5  = {16{8'hA5}};
      pat = 128'h0123456789ABCDEF0123456789ABCDEF;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, '0);
      drive(1, 1'b0, 1'b0, 32'h0, '0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset mem_is_input_valid", DW'(mem_is_input_valid), DW'(0));
      check_eq("reset mem_read", DW'(mem_read), DW'(0));
      check_eq("reset mem_write", DW'(mem_write), DW'(0));
      check_eq("reset p0_resp_valid", DW'(p0_resp_valid), DW'(0));
      check_eq("reset p1_resp_valid", DW'(p1_resp_valid), DW'(0));
      check_eq("reset p0_resp_dout", p0_resp_dout, '0);
      check_eq("reset p1_resp_dout", p1_resp_dout, '0);
      reset = 1'b0;

      preload(8'h10, a5);
      for (int i = 1; i <= 4; i++) preload(8'(i), {16{8'(8'h11 * i)}});

      run_txn(0, 1'b0, 32'h10, '0, a5, "single_read", acc_a);

      run_txn(1, 1'b1, 32'h7, pat, '0, "p1_write", acc_a);
      run_txn(1, 1'b0, 32'h7, '0, pat, "p1_read_back", acc_b);
      check_eq("write_read accept_gap", DW'(acc_b - acc_a), DW'(54));

      prev = 0;
      for (int i = 1; i <= 4; i++) begin
         run_txn(0, 1'b0, 32'(i), '0, {16{8'(8'h11 * i)}}, $sformatf("b2b_read%0d", i), acc_a);
         if (i > 1) check_eq($sformatf("b2b gap%0d", i), DW'(acc_a - prev), DW'(54));
         prev = acc_a;
      end

      // Contention: both ports valid out of reset and held until served.
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1'b1, 1'b0, 32'h20, '0);
      drive(1, 1'b1, 1'b0, 32'h21, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      rst_cyc = cyc; n_acc = 0; p0_n = 0; p1_n = 0; cont_both = 0;
      for (int k = 0; k < 400; k++) begin
         if (p0_req_ready && p1_req_ready) cont_both++;
         if (p0_req_valid && p0_req_ready && n_acc < 8) begin
            acc_c[n_acc] = cyc; acc_p[n_acc] = 0; n_acc++; p0_n++;
         end else if (p1_req_valid && p1_req_ready && n_acc < 8) begin
            acc_c[n_acc] = cyc; acc_p[n_acc] = 1; n_acc++; p1_n++;
         end
         if (n_acc >= 5 && cyc >= acc_c[4] + 55) break;
         @(negedge clk);
         if (p1_n >= 2) p1_req_valid = 1'b0;
         if (p0_n >= 3) p0_req_valid = 1'b0;
         #1;
      end
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      check_eq("contention accepts", DW'(n_acc), DW'(5));
      check_eq("contention both_ready", DW'(cont_both), DW'(0));
      if (n_acc == 5) begin
         check_eq("contention first_cycle", DW'(acc_c[0]), DW'(rst_cyc));
         for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("contention port%0d", i), DW'(acc_p[i]), DW'(i % 2));
            check_eq($sformatf("contention cycle%0d", i), DW'(acc_c[i] - acc_c[0]), DW'(54 * i));
         end
      end

      // Reset in cycle 20 of a p1 read.
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 32'h30, '0);
      #1;
      check_eq("midrst p1_ready", DW'(p1_req_ready), DW'(1));
      acc_a = cyc;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) p1_req_valid = 1'b0;
         #1;
      end
      check_eq("midrst cycle20", DW'(cyc - acc_a), DW'(20));
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_eq("midrst mem_is_input_valid", DW'(mem_is_input_valid), DW'(0));
      check_eq("midrst mem_read", DW'(mem_read), DW'(0));
      check_eq("midrst mem_write", DW'(mem_write), DW'(0));
      check_eq("midrst mem_addr", DW'(mem_addr), DW'(0));
      check_eq("midrst mem_din", mem_din, '0);
      check_eq("midrst p0_ready", DW'(p0_req_ready), DW'(0));
      check_eq("midrst p1_ready", DW'(p1_req_ready), DW'(0));
      check_eq("midrst p0_resp_valid", DW'(p0_resp_valid), DW'(0));
      check_eq("midrst p1_resp_valid", DW'(p1_resp_valid), DW'(0));
      check_eq("midrst p0_resp_dout", p0_resp_dout, '0);
      check_eq("midrst p1_resp_dout", p1_resp_dout, '0);
      reset = 1'b0;
      pulses = 0; ivs = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         #1;
         if (p1_resp_valid) pulses++;
         if (mem_is_input_valid) ivs++;
      end
      check_eq("midrst stale_p1_resp", DW'(pulses), DW'(0));
      check_eq("midrst stale_issue", DW'(ivs), DW'(0));
      run_txn(0, 1'b0, 32'h10, '0, a5, "post_reset_read", acc_a);

      @(negedge clk);
      #3;
      check_eq("mem_read_and_write", DW'(rw_both), DW'(0));
      check_eq("both_ready_ever", DW'(both_rdy), DW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
